cpu7_wbpipe: RTL and testbench

//  Parametrised post-EX back end for the cpu7 core: DEPTH-stage result pipeline from EX to register-file write.
//  - Merges load data at stage LOAD_STAGE.
//  - Provides youngest-first forwarding for rs1/rs2 and flags load-use hazards.
//  - Generalises the empty-pipeline request/acknowledge handshake to any depth.
//  - Sits between the cpu7 EX stage (ALU/CSR result) and the regfile write port.

---
 rtl/cpu7_wbpipe_if.sv | 39 +++
 rtl/cpu7_wbpipe.sv | 75 +++++++
 tb/tb_cpu7_wbpipe.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu7_wbpipe_if.sv
// cpu7_wbpipe_if: EX / memory / regfile side bus of the cpu7 post-EX result pipeline
interface cpu7_wbpipe_if #(
  parameter int XLEN = 32,
  parameter int RFIDX_WIDTH = 5
);
  logic stall;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [RFIDX_WIDTH-1:0] in_rd;
  logic in_regwrite;
  logic in_memtoreg;
  logic [XLEN-1:0] in_result;
  logic [XLEN-1:0] readdata;
  logic [RFIDX_WIDTH-1:0] rs1_idx;
  logic [RFIDX_WIDTH-1:0] rs2_idx;
  logic fwd1_en;
  logic [XLEN-1:0] fwd1_data;
  logic fwd2_en;
  logic [XLEN-1:0] fwd2_data;
  logic load_use;
  logic rf_we;
  logic [RFIDX_WIDTH-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic empty_req;
  logic empty_ack;
  modport master (
    output stall, flush, in_valid, in_rd, in_regwrite, in_memtoreg, in_result, readdata,
           rs1_idx, rs2_idx, empty_req,
    input  in_ready, fwd1_en, fwd1_data, fwd2_en, fwd2_data, load_use, rf_we, rf_waddr,
           rf_wdata, empty_ack
  );
  modport slave (
    input  stall, flush, in_valid, in_rd, in_regwrite, in_memtoreg, in_result, readdata,
           rs1_idx, rs2_idx, empty_req,
    output in_ready, fwd1_en, fwd1_data, fwd2_en, fwd2_data, load_use, rf_we, rf_waddr,
           rf_wdata, empty_ack
  );
endinterface

// File: rtl/cpu7_wbpipe.sv
// cpu7_wbpipe: DEPTH-stage EX-to-regfile pipeline with load merge, youngest-first forwarding and drain handshake
// Optional macro CPU7_FWD_WB_EN: the WB stage also forwards, at lowest priority.
module cpu7_wbpipe #(
  parameter int XLEN = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int DEPTH = 2,
  parameter int LOAD_STAGE = 0
) (
  input logic clk,
  input logic reset,
  cpu7_wbpipe_if.slave bus
);
`ifdef CPU7_FWD_WB_EN
  localparam int FwdStages = DEPTH;
`else
  localparam int FwdStages = DEPTH - 1;
`endif
  logic [DEPTH-1:0] valid, regWrite, memToReg;
  logic [RFIDX_WIDTH-1:0] rd [DEPTH];
  logic [XLEN-1:0] data [DEPTH];
  logic accept, loadUse1, loadUse2;
  assign bus.in_ready = ~bus.stall;
  assign accept = bus.in_valid & ~bus.stall & ~bus.flush;
  assign bus.rf_we = ~reset & ~bus.stall & valid[DEPTH-1] & regWrite[DEPTH-1] & |rd[DEPTH-1];
  assign bus.rf_waddr = rd[DEPTH-1];
  assign bus.rf_wdata = data[DEPTH-1];
  assign bus.load_use = loadUse1 | loadUse2;
  // Advance every stage together unless stalled; a load leaving LOAD_STAGE picks up readdata
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      regWrite <= '0;
      memToReg <= '0;
      bus.empty_ack <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      bus.empty_ack <= bus.empty_req & ~|valid & ~accept;
      if (~bus.stall) begin
        valid <= {valid[DEPTH-2:0], bus.in_valid & ~bus.flush};
        regWrite <= {regWrite[DEPTH-2:0], bus.in_regwrite};
        memToReg <= {memToReg[DEPTH-2:0], bus.in_memtoreg};
        rd[0] <= bus.in_rd;
        data[0] <= bus.in_result;
        for (int i = 1; i < DEPTH; i++) begin
          rd[i] <= rd[i-1];
          data[i] <= (i - 1 == LOAD_STAGE && memToReg[i-1]) ? bus.readdata : data[i-1];
        end
      end
    end
  end
  // Scan oldest to youngest so the youngest matching stage has the final say
  always_comb begin
    bus.fwd1_en = 1'b0;
    bus.fwd1_data = '0;
    loadUse1 = 1'b0;
    bus.fwd2_en = 1'b0;
    bus.fwd2_data = '0;
    loadUse2 = 1'b0;
    for (int i = FwdStages - 1; i >= 0; i--) begin
      if (valid[i] && regWrite[i] && rd[i] == bus.rs1_idx && bus.rs1_idx != '0) begin
        loadUse1 = i < LOAD_STAGE && memToReg[i];
        bus.fwd1_en = ~loadUse1;
        bus.fwd1_data = loadUse1 ? '0 : (i == LOAD_STAGE && memToReg[i]) ? bus.readdata : data[i];
      end
      if (valid[i] && regWrite[i] && rd[i] == bus.rs2_idx && bus.rs2_idx != '0) begin
        loadUse2 = i < LOAD_STAGE && memToReg[i];
        bus.fwd2_en = ~loadUse2;
        bus.fwd2_data = loadUse2 ? '0 : (i == LOAD_STAGE && memToReg[i]) ? bus.readdata : data[i];
      end
    end
  end
endmodule

// File: tb/tb_cpu7_wbpipe.sv
// tb_cpu7_wbpipe: directed scoreboard bench for cpu7_wbpipe (DEPTH=2/LOAD_STAGE=0 and DEPTH=3/LOAD_STAGE=1)
module tb_cpu7_wbpipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [36:0] qa[$];
  logic [36:0] qb[$];
  logic [36:0] ea, eb;
  always #5 clk = ~clk;
  cpu7_wbpipe_if a();
  cpu7_wbpipe_if b();
  cpu7_wbpipe #(.XLEN(32), .RFIDX_WIDTH(5), .DEPTH(2), .LOAD_STAGE(0)) dutA (.clk(clk), .reset(reset), .bus(a));
  cpu7_wbpipe #(.XLEN(32), .RFIDX_WIDTH(5), .DEPTH(3), .LOAD_STAGE(1)) dutB (.clk(clk), .reset(reset), .bus(b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issueA(input logic [4:0] rd, input logic mr, input logic [31:0] res);
    a.in_valid = 1'b1; a.in_rd = rd; a.in_regwrite = 1'b1; a.in_memtoreg = mr; a.in_result = res;
  endtask

  task automatic issueB(input logic [4:0] rd, input logic mr, input logic [31:0] res);
    b.in_valid = 1'b1; b.in_rd = rd; b.in_regwrite = 1'b1; b.in_memtoreg = mr; b.in_result = res;
  endtask

  task automatic idleA;
    a.in_valid = 1'b0; a.in_rd = '0; a.in_regwrite = 1'b0; a.in_memtoreg = 1'b0; a.in_result = '0;
  endtask

  task automatic idleB;
    b.in_valid = 1'b0; b.in_rd = '0; b.in_regwrite = 1'b0; b.in_memtoreg = 1'b0; b.in_result = '0;
  endtask

  // Regfile-write monitors: every write must match the oldest expected write
  always @(negedge clk) begin
    if (a.rf_we === 1'b1) begin
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL A unexpected write: got x%0d=0x%0h, expected no write", a.rf_waddr, a.rf_wdata);
      end else begin
        ea = qa.pop_front();
        chk("A wb addr", 32'(a.rf_waddr), 32'(ea[36:32]));
        chk("A wb data", a.rf_wdata, ea[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (b.rf_we === 1'b1) begin
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL B unexpected write: got x%0d=0x%0h, expected no write", b.rf_waddr, b.rf_wdata);
      end else begin
        eb = qb.pop_front();
        chk("B wb addr", 32'(b.rf_waddr), 32'(eb[36:32]));
        chk("B wb data", b.rf_wdata, eb[31:0]);
      end
    end
  end

  initial begin
    idleA; idleB;
    a.stall = 0; a.flush = 0; a.readdata = 0; a.rs1_idx = 0; a.rs2_idx = 0; a.empty_req = 0;
    b.stall = 0; b.flush = 0; b.readdata = 0; b.rs1_idx = 0; b.rs2_idx = 0; b.empty_req = 0;
    tick; tick;
    @(negedge clk);
    chk("reset empty_ack", 32'(a.empty_ack), 0);
    chk("reset rf_we", 32'(a.rf_we), 0);
    chk("reset fwd1_en", 32'(a.fwd1_en), 0);
    chk("reset load_use", 32'(b.load_use), 0);
    chk("reset in_ready", 32'(a.in_ready), 1);
    tick; reset = 1'b0;
    // back-to-back ALU forwarding
    tick; issueA(5, 0, 32'h11);
    tick; qa.push_back({5'd5, 32'h11}); issueA(6, 0, 32'h12); a.rs1_idx = 5;
    @(negedge clk);
    chk("T1 fwd1_en", 32'(a.fwd1_en), 1);
    chk("T1 fwd1_data", a.fwd1_data, 32'h11);
    chk("T1 load_use", 32'(a.load_use), 0);
    qa.push_back({5'd6, 32'h12});
    tick; idleA; a.rs1_idx = 0;
    @(negedge clk);
    chk("T1 latency rf_we", 32'(a.rf_we), 1);
    tick; tick;
    // WB-only match forwards only with the macro
    issueA(3, 0, 32'h5); qa.push_back({5'd3, 32'h5});
    tick; idleA;
    tick; a.rs1_idx = 3;
    @(negedge clk);
`ifdef CPU7_FWD_WB_EN
    chk("T6 wb fwd1_en", 32'(a.fwd1_en), 1);
    chk("T6 wb fwd1_data", a.fwd1_data, 32'h5);
`else
    chk("T6 wb fwd1_en", 32'(a.fwd1_en), 0);
    chk("T6 wb fwd1_data", a.fwd1_data, 0);
`endif
    tick; a.rs1_idx = 0;
    // flush and x0
    issueA(8, 0, 32'h99); a.flush = 1;
    tick; a.flush = 0; issueA(0, 0, 32'h77);
    tick; idleA; a.rs1_idx = 0; a.rs2_idx = 8;
    @(negedge clk);
    chk("T4 x0 no fwd", 32'(a.fwd1_en), 0);
    chk("T4 flushed no fwd", 32'(a.fwd2_en), 0);
    tick; a.rs2_idx = 0;
    tick;
    issueA(10, 0, 32'hAA); a.stall = 1; a.flush = 1;
    @(negedge clk);
    chk("T4 stall+flush in_ready", 32'(a.in_ready), 0);
    tick; a.stall = 0; a.flush = 0; idleA;
    tick; tick;
    // stall with an instruction in WB
    issueA(9, 0, 32'h33); qa.push_back({5'd9, 32'h33});
    tick; idleA;
    tick; a.stall = 1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("T3 stall rf_we", 32'(a.rf_we), 0);
      chk("T3 stall in_ready", 32'(a.in_ready), 0);
      tick;
    end
    a.stall = 0;
    @(negedge clk);
    chk("T3 release rf_we", 32'(a.rf_we), 1);
    tick;
    @(negedge clk);
    chk("T3 single write", 32'(a.rf_we), 0);
    tick;
    // drain handshake
    issueA(11, 0, 32'h1); qa.push_back({5'd11, 32'h1});
    tick; issueA(12, 0, 32'h2); qa.push_back({5'd12, 32'h2});
    tick; idleA; a.empty_req = 1;
    for (int j = 0; j < 3; j++) begin
      tick;
      @(negedge clk);
      chk("T5 drain ack", 32'(a.empty_ack), (j == 2) ? 1 : 0);
    end
    tick; issueA(13, 0, 32'h3); qa.push_back({5'd13, 32'h3});
    tick; idleA;
    @(negedge clk);
    chk("T5 drop on insert", 32'(a.empty_ack), 0);
    tick; tick; tick;
    @(negedge clk);
    chk("T5 re-ack", 32'(a.empty_ack), 1);
    tick; a.empty_req = 0;
    @(negedge clk);
    chk("T5 ack held", 32'(a.empty_ack), 1);
    tick;
    @(negedge clk);
    chk("T5 drop on req low", 32'(a.empty_ack), 0);
    // reset mid-operation discards in-flight work
    tick; issueA(14, 0, 32'h4);
    tick; issueA(15, 0, 32'h5);
    tick; idleA; reset = 1;
    @(negedge clk);
    chk("mid-reset rf_we", 32'(a.rf_we), 0);
    tick; reset = 0;
    tick; tick; tick;
    // load-use then load forwarding from LOAD_STAGE
    issueB(7, 1, 32'h100);
    tick; idleB; b.rs1_idx = 7;
    @(negedge clk);
    chk("T2 load_use", 32'(b.load_use), 1);
    chk("T2 stall fwd1_en", 32'(b.fwd1_en), 0);
    tick; b.readdata = 32'hCAFE;
    @(negedge clk);
    chk("T2 load fwd1_en", 32'(b.fwd1_en), 1);
    chk("T2 load fwd1_data", b.fwd1_data, 32'hCAFE);
    chk("T2 load_use cleared", 32'(b.load_use), 0);
    qb.push_back({5'd7, 32'hCAFE});
    tick; b.readdata = 0; b.rs1_idx = 0;
    tick; tick;
    // youngest ALU result beats an older load of the same rd
    issueB(7, 1, 32'h200);
    tick; issueB(7, 0, 32'h55);
    tick; idleB; b.readdata = 32'hBEEF; b.rs1_idx = 7; b.rs2_idx = 7;
    qb.push_back({5'd7, 32'hBEEF}); qb.push_back({5'd7, 32'h55});
    @(negedge clk);
    chk("B youngest fwd1_data", b.fwd1_data, 32'h55);
    chk("B youngest fwd2_en", 32'(b.fwd2_en), 1);
    chk("B youngest fwd2_data", b.fwd2_data, 32'h55);
    chk("B youngest load_use", 32'(b.load_use), 0);
    tick; b.readdata = 0;
    @(negedge clk);
    chk("B stage1 fwd1_data", b.fwd1_data, 32'h55);
    tick; b.rs1_idx = 0; b.rs2_idx = 0;
    tick; tick; tick;
    chk("A queue drained", 32'(qa.size()), 0);
    chk("B queue drained", 32'(qb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
